// File: rtl/reg_wb_sched.sv
// reg_wb_sched: register scoreboard and writeback scheduler.
// Tracks pending register writes so dependent issues stall. Arbitrates
// ALU (EXEC) and load (MEM) writebacks onto one register-file write port.
// Provides a flush/drain mode that blocks issue until every pending write
// has retired.
module reg_wb_sched #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        FLUSH,
   // decode-stage issue request
   input  logic        ISSUE_VALID,
   input  logic        ISSUE_WR,
   input  logic [4:0]  ISSUE_RD,
   input  logic [4:0]  ISSUE_RS1,
   input  logic [4:0]  ISSUE_RS2,
   output logic        ISSUE_READY,
   output logic        STALL,
   // ALU writeback requester
   input  logic        EXEC_VALID,
   input  logic [4:0]  EXEC_ADDR,
   input  logic [31:0] EXEC_DATA,
   output logic        EXEC_READY,
   // load writeback requester
   input  logic        MEM_VALID,
   input  logic [4:0]  MEM_ADDR,
   input  logic [31:0] MEM_DATA,
   output logic        MEM_READY,
   // register-file write port (WADDR == 0 means no write)
   output logic [4:0]  WADDR,
   output logic [31:0] WDATA,
   // scoreboard
   output logic [31:0] BUSY
);

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   // Saturation point of the EXEC starvation counter, held in the counter's width.
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [0:0]  state_q,  state_d;
   logic [31:0] busy_q,   busy_d;
   logic [3:0]  starve_q, starve_d;
   logic [4:0]  waddr_q,  waddr_d;
   logic [31:0] wdata_q,  wdata_d;

   logic        src_busy_s;
   logic        dst_busy_s;
   logic        issue_ready_s;
   logic        issue_set_s;
   logic        exec_grant_s;
   logic        mem_grant_s;
   logic        wb_valid_s;
   logic [4:0]  wb_addr_s;
   logic [31:0] wb_data_s;

   // Hazard lookup: sources must be clean; the destination only matters when written.
   always_comb begin
      src_busy_s = busy_q[ISSUE_RS1] | busy_q[ISSUE_RS2];
      if (ISSUE_WR) begin
         dst_busy_s = busy_q[ISSUE_RD];
      end else begin
         dst_busy_s = 1'b0;
      end
   end

   // Issue acceptance. Uses only registered BUSY, so a writeback clearing a
   // register this cycle does not release a dependent issue until next cycle.
   always_comb begin
      issue_ready_s = 1'b0;
      if (RST || FLUSH) begin
         issue_ready_s = 1'b0;
      end else if (state_q == ST_RUN) begin
         issue_ready_s = ~src_busy_s & ~dst_busy_s;
      end else begin
         issue_ready_s = 1'b0;
      end
      issue_set_s = ISSUE_VALID & issue_ready_s & ISSUE_WR & (ISSUE_RD != 5'd0);
   end

   // Writeback arbitration: MEM has priority, but EXEC wins once it has lost
   // STARVE_LIMIT times in a row. No grants while reset is asserted.
   always_comb begin
      exec_grant_s = 1'b0;
      mem_grant_s  = 1'b0;
      if (RST) begin
         exec_grant_s = 1'b0;
         mem_grant_s  = 1'b0;
      end else if (EXEC_VALID && MEM_VALID) begin
         if (starve_q == LIMIT) begin
            exec_grant_s = 1'b1;
         end else begin
            mem_grant_s  = 1'b1;
         end
      end else if (EXEC_VALID) begin
         exec_grant_s = 1'b1;
      end else if (MEM_VALID) begin
         mem_grant_s  = 1'b1;
      end else begin
         exec_grant_s = 1'b0;
         mem_grant_s  = 1'b0;
      end
   end

   // Mux the granted requester onto the internal writeback bus.
   always_comb begin
      wb_valid_s = exec_grant_s | mem_grant_s;
      if (exec_grant_s) begin
         wb_addr_s = EXEC_ADDR;
         wb_data_s = EXEC_DATA;
      end else if (mem_grant_s) begin
         wb_addr_s = MEM_ADDR;
         wb_data_s = MEM_DATA;
      end else begin
         wb_addr_s = 5'd0;
         wb_data_s = wdata_q;
      end
   end

   // Starvation counter: cleared on EXEC grant, counts EXEC losses, saturates.
   always_comb begin
      starve_d = starve_q;
      if (exec_grant_s) begin
         starve_d = 4'd0;
      end else if (EXEC_VALID && (starve_q < LIMIT)) begin
         starve_d = starve_q + 4'd1;
      end else begin
         starve_d = starve_q;
      end
   end

   // Scoreboard update: clear on writeback first, then set on issue so a
   // same-register set wins. Register 0 is never tracked.
   always_comb begin
      busy_d = busy_q;
      if (wb_valid_s) begin
         busy_d[wb_addr_s] = 1'b0;
      end else begin
         busy_d = busy_q;
      end
      if (issue_set_s) begin
         busy_d[ISSUE_RD] = 1'b1;
      end else begin
         busy_d[0] = 1'b0;
      end
      busy_d[0] = 1'b0;
   end

   // Write port next state: address reads 0 unless a real write happens;
   // data holds when nothing is written (including address-0 writebacks).
   always_comb begin
      waddr_d = 5'd0;
      wdata_d = wdata_q;
      if (wb_valid_s && (wb_addr_s != 5'd0)) begin
         waddr_d = wb_addr_s;
         wdata_d = wb_data_s;
      end else begin
         waddr_d = 5'd0;
         wdata_d = wdata_q;
      end
   end

   // Flush FSM: enter DRAIN on flush, leave once every pending write retired.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (FLUSH) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if ((busy_q == 32'd0) && !FLUSH) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State registers with asynchronous reset to the idle/empty condition.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_RUN;
         busy_q   <= 32'd0;
         starve_q <= 4'd0;
         waddr_q  <= 5'd0;
         wdata_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         starve_q <= starve_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign ISSUE_READY = issue_ready_s;
   assign STALL       = ISSUE_VALID & ~issue_ready_s;
   assign EXEC_READY  = exec_grant_s;
   assign MEM_READY   = mem_grant_s;
   assign WADDR       = waddr_q;
   assign WDATA       = wdata_q;
   assign BUSY        = busy_q;

endmodule

// File: tb/tb_reg_wb_sched.sv
// Directed testbench for reg_wb_sched with hand-computed expectations.
module tb_reg_wb_sched;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        FLUSH = 1'b0;
   logic        ISSUE_VALID = 1'b0;
   logic        ISSUE_WR = 1'b0;
   logic [4:0]  ISSUE_RD = 5'd0;
   logic [4:0]  ISSUE_RS1 = 5'd0;
   logic [4:0]  ISSUE_RS2 = 5'd0;
   logic        ISSUE_READY;
   logic        STALL;
   logic        EXEC_VALID = 1'b0;
   logic [4:0]  EXEC_ADDR = 5'd0;
   logic [31:0] EXEC_DATA = 32'd0;
   logic        EXEC_READY;
   logic        MEM_VALID = 1'b0;
   logic [4:0]  MEM_ADDR = 5'd0;
   logic [31:0] MEM_DATA = 32'd0;
   logic        MEM_READY;
   logic [4:0]  WADDR;
   logic [31:0] WDATA;
   logic [31:0] BUSY;

   int n_checks = 0;
   int n_fail   = 0;

   reg_wb_sched #(.STARVE_LIMIT(4)) dut (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
      .ISSUE_VALID(ISSUE_VALID), .ISSUE_WR(ISSUE_WR), .ISSUE_RD(ISSUE_RD),
      .ISSUE_RS1(ISSUE_RS1), .ISSUE_RS2(ISSUE_RS2),
      .ISSUE_READY(ISSUE_READY), .STALL(STALL),
      .EXEC_VALID(EXEC_VALID), .EXEC_ADDR(EXEC_ADDR), .EXEC_DATA(EXEC_DATA),
      .EXEC_READY(EXEC_READY),
      .MEM_VALID(MEM_VALID), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
      .MEM_READY(MEM_READY),
      .WADDR(WADDR), .WDATA(WDATA), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      FLUSH = 1'b0; ISSUE_VALID = 1'b0; ISSUE_WR = 1'b0;
      ISSUE_RD = 5'd0; ISSUE_RS1 = 5'd0; ISSUE_RS2 = 5'd0;
      EXEC_VALID = 1'b0; EXEC_ADDR = 5'd0; EXEC_DATA = 32'd0;
      MEM_VALID = 1'b0; MEM_ADDR = 5'd0; MEM_DATA = 32'd0;
   endtask

   task automatic test_reset();
      ISSUE_VALID = 1'b1; EXEC_VALID = 1'b1; MEM_VALID = 1'b1;
      #1;
      n_checks++; if (BUSY !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h expected %h", BUSY, 32'd0); end
      n_checks++; if (WADDR !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0d expected 0", WADDR); end
      n_checks++; if (WDATA !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", WDATA); end
      n_checks++; if ({ISSUE_READY, EXEC_READY, MEM_READY} !== 3'b000) begin n_fail++; $display("FAIL reset_readies: got %b expected 000", {ISSUE_READY, EXEC_READY, MEM_READY}); end
      step(); step();
      idle_inputs();
      RST = 1'b0;
      step();
      n_checks++; if (WADDR !== 5'd0) begin n_fail++; $display("FAIL post_reset_waddr: got %0d expected 0", WADDR); end
   endtask

   task automatic test_raw_hazard();
      ISSUE_VALID = 1'b1; ISSUE_WR = 1'b1; ISSUE_RD = 5'd5;
      #1;
      n_checks++; if ({ISSUE_READY, STALL} !== 2'b10) begin n_fail++; $display("FAIL raw_first_issue: got %b expected 10", {ISSUE_READY, STALL}); end
      step();
      n_checks++; if (BUSY !== 32'h0000_0020) begin n_fail++; $display("FAIL raw_busy_set: got %h expected 00000020", BUSY); end
      ISSUE_WR = 1'b0; ISSUE_RD = 5'd0; ISSUE_RS1 = 5'd5;
      #1;
      n_checks++; if ({ISSUE_READY, STALL} !== 2'b01) begin n_fail++; $display("FAIL raw_stall1: got %b expected 01", {ISSUE_READY, STALL}); end
      step();
      n_checks++; if ({ISSUE_READY, STALL} !== 2'b01) begin n_fail++; $display("FAIL raw_stall2: got %b expected 01", {ISSUE_READY, STALL}); end
      EXEC_VALID = 1'b1; EXEC_ADDR = 5'd5; EXEC_DATA = 32'h1111_2222;
      #1;
      n_checks++; if (EXEC_READY !== 1'b1) begin n_fail++; $display("FAIL raw_exec_ready: got %b expected 1", EXEC_READY); end
      n_checks++; if (ISSUE_READY !== 1'b0) begin n_fail++; $display("FAIL raw_no_bypass: got %b expected 0", ISSUE_READY); end
      step();
      EXEC_VALID = 1'b0;
      n_checks++; if (WADDR !== 5'd5 || WDATA !== 32'h1111_2222) begin n_fail++; $display("FAIL raw_wb: got %0d/%h expected 5/11112222", WADDR, WDATA); end
      n_checks++; if (BUSY !== 32'd0) begin n_fail++; $display("FAIL raw_busy_clear: got %h expected 0", BUSY); end
      #1;
      n_checks++; if ({ISSUE_READY, STALL} !== 2'b10) begin n_fail++; $display("FAIL raw_release: got %b expected 10", {ISSUE_READY, STALL}); end
      ISSUE_VALID = 1'b0; ISSUE_RS1 = 5'd0;
      step();
      n_checks++; if (WADDR !== 5'd0 || WDATA !== 32'h1111_2222) begin n_fail++; $display("FAIL raw_idle_hold: got %0d/%h expected 0/11112222", WADDR, WDATA); end
   endtask

   task automatic test_starve();
      logic exp_exec;
      EXEC_VALID = 1'b1; EXEC_ADDR = 5'd10; EXEC_DATA = 32'hAAAA_0001;
      MEM_VALID  = 1'b1; MEM_ADDR  = 5'd20; MEM_DATA  = 32'hBBBB_0002;
      for (int i = 0; i < 10; i++) begin
         exp_exec = ((i % 5) == 4);
         #1;
         n_checks++; if ({EXEC_READY, MEM_READY} !== {exp_exec, ~exp_exec}) begin n_fail++; $display("FAIL starve_grant[%0d]: got %b expected %b", i, {EXEC_READY, MEM_READY}, {exp_exec, ~exp_exec}); end
         step();
         n_checks++; if (WADDR !== (exp_exec ? 5'd10 : 5'd20) || WDATA !== (exp_exec ? 32'hAAAA_0001 : 32'hBBBB_0002)) begin n_fail++; $display("FAIL starve_wb[%0d]: got %0d/%h exec_expected=%b", i, WADDR, WDATA, exp_exec); end
      end
      idle_inputs();
      step();
   endtask

   task automatic test_same_edge();
      ISSUE_VALID = 1'b1; ISSUE_WR = 1'b1; ISSUE_RD = 5'd7;
      MEM_VALID = 1'b1; MEM_ADDR = 5'd7; MEM_DATA = 32'h0000_0777;
      #1;
      n_checks++; if ({ISSUE_READY, MEM_READY} !== 2'b11) begin n_fail++; $display("FAIL same_readies: got %b expected 11", {ISSUE_READY, MEM_READY}); end
      step();
      ISSUE_VALID = 1'b0; ISSUE_WR = 1'b0; ISSUE_RD = 5'd0;
      n_checks++; if (BUSY !== 32'h0000_0080 || WADDR !== 5'd7) begin n_fail++; $display("FAIL same_set_wins: got %h/%0d expected 00000080/7", BUSY, WADDR); end
      step();
      MEM_VALID = 1'b0;
      n_checks++; if (BUSY !== 32'd0) begin n_fail++; $display("FAIL same_cleanup: got %h expected 0", BUSY); end
   endtask

   task automatic test_flush_drain();
      ISSUE_VALID = 1'b1; ISSUE_WR = 1'b1; ISSUE_RD = 5'd3;
      step();
      n_checks++; if (BUSY !== 32'h0000_0008) begin n_fail++; $display("FAIL drain_setup: got %h expected 00000008", BUSY); end
      FLUSH = 1'b1; ISSUE_RD = 5'd9;
      #1;
      n_checks++; if ({ISSUE_READY, STALL} !== 2'b01) begin n_fail++; $display("FAIL flush_suppress: got %b expected 01", {ISSUE_READY, STALL}); end
      step();
      FLUSH = 1'b0; ISSUE_WR = 1'b0; ISSUE_RD = 5'd0;
      n_checks++; if (BUSY !== 32'h0000_0008) begin n_fail++; $display("FAIL flush_no_set: got %h expected 00000008", BUSY); end
      MEM_VALID = 1'b1; MEM_ADDR = 5'd3; MEM_DATA = 32'h0000_0333;
      #1;
      n_checks++; if ({ISSUE_READY, MEM_READY} !== 2'b01) begin n_fail++; $display("FAIL drain_readies: got %b expected 01", {ISSUE_READY, MEM_READY}); end
      step();
      MEM_VALID = 1'b0;
      n_checks++; if (BUSY !== 32'd0 || WADDR !== 5'd3) begin n_fail++; $display("FAIL drain_retire: got %h/%0d expected 0/3", BUSY, WADDR); end
      #1;
      n_checks++; if (ISSUE_READY !== 1'b0) begin n_fail++; $display("FAIL drain_still: got %b expected 0", ISSUE_READY); end
      step();
      n_checks++; if (ISSUE_READY !== 1'b1) begin n_fail++; $display("FAIL drain_to_run: got %b expected 1", ISSUE_READY); end
      ISSUE_VALID = 1'b0;
      step();
   endtask

   task automatic test_addr0();
      ISSUE_VALID = 1'b1; ISSUE_WR = 1'b1; ISSUE_RD = 5'd4;
      step();
      idle_inputs();
      EXEC_VALID = 1'b1; EXEC_ADDR = 5'd0; EXEC_DATA = 32'hDEAD_BEEF;
      #1;
      n_checks++; if (EXEC_READY !== 1'b1) begin n_fail++; $display("FAIL addr0_ready: got %b expected 1", EXEC_READY); end
      step();
      n_checks++; if (WADDR !== 5'd0 || BUSY !== 32'h0000_0010) begin n_fail++; $display("FAIL addr0_wb: got %0d/%h expected 0/00000010", WADDR, BUSY); end
      EXEC_ADDR = 5'd4;
      step();
      EXEC_VALID = 1'b0;
      n_checks++; if (BUSY !== 32'd0 || BUSY[0] !== 1'b0) begin n_fail++; $display("FAIL addr0_cleanup: got %h expected 0", BUSY); end
   endtask

   task automatic test_async_reset();
      logic [4:0] rds [0:2];
      rds[0] = 5'd8; rds[1] = 5'd10; rds[2] = 5'd11;
      ISSUE_VALID = 1'b1; ISSUE_WR = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ISSUE_RD = rds[i];
         step();
      end
      ISSUE_RD = 5'd9;
      MEM_VALID = 1'b1; MEM_ADDR = 5'd9; MEM_DATA = 32'h9999_9999;
      step();
      idle_inputs();
      n_checks++; if (BUSY !== 32'h0000_0F00 || WADDR !== 5'd9) begin n_fail++; $display("FAIL areset_setup: got %h/%0d expected 00000f00/9", BUSY, WADDR); end
      #2;
      RST = 1'b1;
      EXEC_VALID = 1'b1; EXEC_ADDR = 5'd1;
      #1;
      n_checks++; if (BUSY !== 32'd0 || WADDR !== 5'd0 || WDATA !== 32'd0) begin n_fail++; $display("FAIL areset_clear: got %h/%0d/%h expected 0/0/0", BUSY, WADDR, WDATA); end
      n_checks++; if (EXEC_READY !== 1'b0) begin n_fail++; $display("FAIL areset_exec_ready: got %b expected 0", EXEC_READY); end
      step();
      idle_inputs();
      RST = 1'b0;
      step();
      // reset in the middle of a drain discards pending state
      ISSUE_VALID = 1'b1; ISSUE_WR = 1'b1; ISSUE_RD = 5'd2;
      step();
      ISSUE_VALID = 1'b0; ISSUE_WR = 1'b0; FLUSH = 1'b1;
      step();
      FLUSH = 1'b0;
      #2;
      RST = 1'b1;
      #1;
      n_checks++; if (BUSY !== 32'd0) begin n_fail++; $display("FAIL drain_reset_busy: got %h expected 0", BUSY); end
      step();
      RST = 1'b0;
      ISSUE_VALID = 1'b1; ISSUE_RS1 = 5'd2;
      #1;
      n_checks++; if (ISSUE_READY !== 1'b1) begin n_fail++; $display("FAIL drain_reset_run: got %b expected 1", ISSUE_READY); end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_raw_hazard();
      test_starve();
      test_same_edge();
      test_flush_drain();
      test_addr0();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
